// File: rtl/sys_read_unit_if.sv
// Bus between the processor/host side and the console-input syscall responder.
// The master drives host pushes and syscall requests; the slave answers them.
interface sys_read_unit_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic [31:0]   in_data;
  logic          in_ready;
  logic          req;
  logic [31:0]   rs;
  logic [31:0]   rd;
  logic          done;
  logic          stall;
  logic          err;
  logic [CW-1:0] count;

  modport master (
    output in_valid, in_data, req, rs,
    input  in_ready, rd, done, stall, err, count
  );

  modport slave (
    input  in_valid, in_data, req, rs,
    output in_ready, rd, done, stall, err, count
  );
endinterface

// File: rtl/sys_read_unit.sv
// Console-input syscall responder: buffers host words in a circular FIFO and
// returns the head word to the processor on a read syscall (rs == 3), stalling
// the pipeline while the FIFO is empty and optionally timing out with err.
module sys_read_unit #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  sys_read_unit_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [31:0]   RS_READ    = 32'd3;
  // Last timer value before giving up; unused (wraps) when TIMEOUT is 0.
  localparam logic [31:0]   TIMER_LAST = 32'(TIMEOUT) - 32'd1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [31:0]   rd_q, rd_d;
  logic          done_q, done_d;
  logic          stall_q, stall_d;
  logic          err_q, err_d;

  logic          ready_s;
  logic          push_s;
  logic          pop_s;
  logic          read_req_s;
  logic          has_data_s;
  logic          timed_out_s;

  // Full is the only condition that blocks a push; a same-cycle pop does not help.
  assign ready_s     = (count_q != FULL_COUNT);
  assign push_s      = bus.in_valid && ready_s;
  assign read_req_s  = bus.req && (bus.rs == RS_READ);
  assign has_data_s  = (count_q != '0);
  assign timed_out_s = (TIMEOUT != 0) && (32'(timer_q) == TIMER_LAST);

  assign bus.in_ready = ready_s;
  assign bus.count    = count_q;
  assign bus.rd       = rd_q;
  assign bus.done     = done_q;
  assign bus.stall    = stall_q;
  assign bus.err      = err_q;

  // FSM next state, pop decision, timer and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    rd_d    = rd_q;
    err_d   = 1'b0;
    pop_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (read_req_s) begin
          if (has_data_s) begin
            state_d = S_RESP;
            rd_d    = mem_q[rd_ptr_q];
            pop_s   = 1'b1;
          end else begin
            state_d = S_WAIT;
            timer_d = '0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        timer_d = timer_q + TW'(1);
        // Data arriving on the timeout cycle still wins.
        if (has_data_s) begin
          state_d = S_RESP;
          rd_d    = mem_q[rd_ptr_q];
          pop_s   = 1'b1;
        end else if (timed_out_s) begin
          state_d = S_RESP;
          rd_d    = '0;
          err_d   = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    done_d  = (state_d == S_RESP);
    stall_d = (state_d == S_WAIT);
  end

  // FIFO pointer and occupancy bookkeeping from this cycle's push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  // State, pointers, occupancy and registered outputs; reset flushes the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      timer_q  <= '0;
      rd_q     <= '0;
      done_q   <= 1'b0;
      stall_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      timer_q  <= timer_d;
      rd_q     <= rd_d;
      done_q   <= done_d;
      stall_q  <= stall_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_sys_read_unit.sv
// Bench for sys_read_unit: two instances (TIMEOUT=0 and TIMEOUT=4) driven by
// directed vectors, checked every cycle against a queue-style behavioural model
// plus hand-computed literal expectations.
module tb_sys_read_unit;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  sys_read_unit_if #(.DEPTH(DEPTH)) bus0 ();
  sys_read_unit_if #(.DEPTH(DEPTH)) bus4 ();

  sys_read_unit #(.DEPTH(DEPTH), .TIMEOUT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  sys_read_unit #(.DEPTH(DEPTH), .TIMEOUT(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  // Index 0 drives/observes the TIMEOUT=0 instance, index 1 the TIMEOUT=4 one.
  logic          v_in_valid [2];
  logic [31:0]   v_in_data  [2];
  logic          v_req      [2];
  logic [31:0]   v_rs       [2];
  logic          o_ready    [2];
  logic [31:0]   o_rd       [2];
  logic          o_done     [2];
  logic          o_stall    [2];
  logic          o_err      [2];
  logic [CW-1:0] o_count    [2];

  assign bus0.in_valid = v_in_valid[0];
  assign bus0.in_data  = v_in_data[0];
  assign bus0.req      = v_req[0];
  assign bus0.rs       = v_rs[0];
  assign bus4.in_valid = v_in_valid[1];
  assign bus4.in_data  = v_in_data[1];
  assign bus4.req      = v_req[1];
  assign bus4.rs       = v_rs[1];
  assign o_ready[0] = bus0.in_ready;
  assign o_rd[0]    = bus0.rd;
  assign o_done[0]  = bus0.done;
  assign o_stall[0] = bus0.stall;
  assign o_err[0]   = bus0.err;
  assign o_count[0] = bus0.count;
  assign o_ready[1] = bus4.in_ready;
  assign o_rd[1]    = bus4.rd;
  assign o_done[1]  = bus4.done;
  assign o_stall[1] = bus4.stall;
  assign o_err[1]   = bus4.err;
  assign o_count[1] = bus4.count;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The FIFO is an append-only word log; occupancy is tail - head.
  logic [31:0] m_log [2][0:127];
  int          m_head [2] = '{0, 0};
  int          m_tail [2] = '{0, 0};
  bit          m_waiting [2] = '{1'b0, 1'b0};
  int          m_waited  [2] = '{0, 0};
  bit          m_done [2] = '{1'b0, 1'b0};
  bit          m_err  [2] = '{1'b0, 1'b0};
  logic [31:0] m_rd   [2] = '{32'd0, 32'd0};
  int          m_tmo  [2] = '{0, 4};

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      for (int k = 0; k < 2; k++) begin
        int cnt;
        bit responding;
        if (!rst_n) begin
          m_head[k] = 0; m_tail[k] = 0; m_waiting[k] = 1'b0; m_waited[k] = 0;
          m_done[k] = 1'b0; m_err[k] = 1'b0; m_rd[k] = 32'd0;
        end else begin
          cnt        = m_tail[k] - m_head[k];
          responding = m_done[k];
          m_done[k]  = 1'b0;
          m_err[k]   = 1'b0;
          if (m_waiting[k]) begin
            m_waited[k]++;
            if (cnt > 0) begin
              m_rd[k] = m_log[k][m_head[k]]; m_head[k]++;
              m_done[k] = 1'b1; m_waiting[k] = 1'b0;
            end else if (m_tmo[k] != 0 && m_waited[k] == m_tmo[k]) begin
              m_rd[k] = 32'd0; m_err[k] = 1'b1;
              m_done[k] = 1'b1; m_waiting[k] = 1'b0;
            end
          end else if (!responding && v_req[k] && v_rs[k] == 32'd3) begin
            if (cnt > 0) begin
              m_rd[k] = m_log[k][m_head[k]]; m_head[k]++;
              m_done[k] = 1'b1;
            end else begin
              m_waiting[k] = 1'b1; m_waited[k] = 0;
            end
          end
          if (v_in_valid[k] && cnt < DEPTH) begin
            m_log[k][m_tail[k]] = v_in_data[k];
            m_tail[k]++;
          end
        end
      end
    end
  end

  // Compare every DUT output against the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("dut%0d.count", k), 32'(o_count[k]), 32'(m_tail[k] - m_head[k]));
        chk($sformatf("dut%0d.in_ready", k), 32'(o_ready[k]), 32'((m_tail[k] - m_head[k]) < DEPTH));
        chk($sformatf("dut%0d.stall", k), 32'(o_stall[k]), 32'(m_waiting[k]));
        chk($sformatf("dut%0d.done", k), 32'(o_done[k]), 32'(m_done[k]));
        chk($sformatf("dut%0d.err", k), 32'(o_err[k]), 32'(m_err[k]));
        chk($sformatf("dut%0d.rd", k), o_rd[k], m_rd[k]);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input logic [31:0] d);
    v_in_valid[k] = 1'b1;
    v_in_data[k]  = d;
    tick();
    v_in_valid[k] = 1'b0;
  endtask

  task automatic syscall(input int k, input logic [31:0] r);
    v_req[k] = 1'b1;
    v_rs[k]  = r;
    tick();
    v_req[k] = 1'b0;
  endtask

  task automatic read_expect(input int k, input logic [31:0] exp, input string tag);
    syscall(k, 32'd3);
    chk({tag, "_done"}, 32'(o_done[k]), 32'd1);
    chk({tag, "_rd"}, o_rd[k], exp);
    chk({tag, "_stall"}, 32'(o_stall[k]), 32'd0);
    tick();
  endtask

  initial begin
    logic [31:0] exp1 [3];
    int stall_seen;
    exp1 = '{32'h11, 32'h22, 32'h33};
    for (int k = 0; k < 2; k++) begin
      v_in_valid[k] = 1'b0; v_in_data[k] = 32'd0; v_req[k] = 1'b0; v_rs[k] = 32'd0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    chk("rst_ready", 32'(o_ready[0]), 32'd1);
    chk("rst_count", 32'(o_count[0]), 32'd0);
    chk("rst_stall", 32'(o_stall[0]), 32'd0);
    chk("rst_done", 32'(o_done[0]), 32'd0);
    chk("rst_err", 32'(o_err[0]), 32'd0);
    chk("rst_rd", o_rd[0], 32'd0);

    // Hits: three words, three reads spaced 3 cycles apart
    push(0, 32'h11); push(0, 32'h22); push(0, 32'h33);
    chk("hit_count3", 32'(o_count[0]), 32'd3);
    for (int i = 0; i < 3; i++) begin
      syscall(0, 32'd3);
      chk("hit_done", 32'(o_done[0]), 32'd1);
      chk("hit_rd", o_rd[0], exp1[i]);
      chk("hit_stall", 32'(o_stall[0]), 32'd0);
      chk("hit_count", 32'(o_count[0]), 32'(2 - i));
      tick(); tick();
    end

    // Miss with TIMEOUT=0: data pushed 5 cycles after req
    syscall(0, 32'd3);
    stall_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (o_stall[0]) stall_seen++;
      if (i == 4) begin
        v_in_valid[0] = 1'b1; v_in_data[0] = 32'hDEADBEEF;
      end
      tick();
      v_in_valid[0] = 1'b0;
    end
    chk("miss_stall_cycles", 32'(stall_seen), 32'd6);
    chk("miss_done", 32'(o_done[0]), 32'd1);
    chk("miss_rd", o_rd[0], 32'hDEADBEEF);
    chk("miss_err", 32'(o_err[0]), 32'd0);
    chk("miss_stall_off", 32'(o_stall[0]), 32'd0);
    tick();

    // Timeout with TIMEOUT=4: first a hit so rd is non-zero, then an empty read
    push(1, 32'h77);
    read_expect(1, 32'h77, "t4_hit");
    syscall(1, 32'd3);
    stall_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (o_stall[1]) stall_seen++;
      tick();
    end
    chk("tmo_stall_cycles", 32'(stall_seen), 32'd4);
    chk("tmo_done", 32'(o_done[1]), 32'd1);
    chk("tmo_err", 32'(o_err[1]), 32'd1);
    chk("tmo_rd", o_rd[1], 32'd0);
    chk("tmo_count", 32'(o_count[1]), 32'd0);
    tick();
    chk("tmo_err_clear", 32'(o_err[1]), 32'd0);

    // Full FIFO, dropped pushes, refill, wrap-around read-out
    for (int i = 0; i < 8; i++) push(0, 32'hA0 + 32'(i));
    chk("full_count", 32'(o_count[0]), 32'd8);
    chk("full_ready", 32'(o_ready[0]), 32'd0);
    push(0, 32'hEE);
    chk("full_drop_count", 32'(o_count[0]), 32'd8);
    v_req[0] = 1'b1; v_rs[0] = 32'd3; v_in_valid[0] = 1'b1; v_in_data[0] = 32'hEF;
    tick();
    v_req[0] = 1'b0; v_in_valid[0] = 1'b0;
    chk("full_pop_rd", o_rd[0], 32'hA0);
    chk("full_pop_count", 32'(o_count[0]), 32'd7);
    push(0, 32'h99);
    chk("refill_count", 32'(o_count[0]), 32'd8);
    for (int i = 1; i < 8; i++) read_expect(0, 32'hA0 + 32'(i), "wrap");
    read_expect(0, 32'h99, "wrap_last");
    chk("wrap_count", 32'(o_count[0]), 32'd0);

    // Non-read syscalls ignored; push+pop in one cycle keeps count
    push(0, 32'h61); push(0, 32'h62);
    syscall(0, 32'd1);
    chk("rs1_done", 32'(o_done[0]), 32'd0);
    chk("rs1_stall", 32'(o_stall[0]), 32'd0);
    chk("rs1_count", 32'(o_count[0]), 32'd2);
    tick();
    syscall(0, 32'd2);
    chk("rs2_done", 32'(o_done[0]), 32'd0);
    chk("rs2_stall", 32'(o_stall[0]), 32'd0);
    chk("rs2_count", 32'(o_count[0]), 32'd2);
    tick();
    v_req[0] = 1'b1; v_rs[0] = 32'd3; v_in_valid[0] = 1'b1; v_in_data[0] = 32'h63;
    tick();
    v_req[0] = 1'b0; v_in_valid[0] = 1'b0;
    chk("pp_rd", o_rd[0], 32'h61);
    chk("pp_count", 32'(o_count[0]), 32'd2);
    tick();
    read_expect(0, 32'h62, "pp_a");
    read_expect(0, 32'h63, "pp_b");

    // Reset in the middle of WAIT
    syscall(0, 32'd3);
    chk("wr_stall_before", 32'(o_stall[0]), 32'd1);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("wr_stall", 32'(o_stall[0]), 32'd0);
    chk("wr_count", 32'(o_count[0]), 32'd0);
    chk("wr_done", 32'(o_done[0]), 32'd0);
    chk("wr_ready", 32'(o_ready[0]), 32'd1);
    tick(); tick();
    rst_n = 1'b1;
    push(0, 32'h5);
    read_expect(0, 32'h5, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
